alu_op_decoder: RTL and testbench
=================================

# alu_op_decoder

Decode stage that turns a raw RV32I instruction word into the operand-select and `alu_control` encoding consumed by the ALU. It is the producer side of the ALU control interface. It sits between instruction fetch and register read/execute. It accepts one instruction per cycle over a valid/ready handshake and registers all decoded fields. A 2-entry skid buffer keeps throughput at 1/cycle under back-pressure. Only OP (0110011) and OP-IMM (0010011) are legal; all other encodings are passed downstream flagged `illegal`.

## Interface
- No parameters; all widths fixed by RV32I.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: decoded bundle is valid.
- `out_ready` in 1: downstream accepts the bundle.
- `alu_control` out 6: ALU operation code.
- `imm_val` out 32: immediate operand.
- `shft_amnt` out 32: shift amount, zero-extended.
- `use_imm` out 1: execute selects `imm_val` instead of rs2 data.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5 each: register indices.
- `illegal` out 1: instruction not supported.

## Operation
- **ALU codes:**
  - 000000 add, 000001 slt, 000010 sltu, 000011 and, 000100 or
  - 000101 xor, 000110 sll, 000111 srl, 001000 sub, 001001 sra
- **OP, funct7 = 0000000:**
  - funct3 000→add, 001→sll, 010→slt, 011→sltu, 100→xor, 101→srl, 110→or, 111→and.
  - `use_imm`=0, `imm_val`=0, `shft_amnt`=0.
- **OP, funct7 = 0100000:**
  - funct3 000→sub, 101→sra.
  - Other funct3 → illegal.
- **OP, any other funct7:** illegal.
- **OP-IMM:**
  - funct3 000→add, 010→slt, 011→sltu, 100→xor, 110→or, 111→and.
  - `imm_val` = sign-extended instr[31:20]; `use_imm`=1; `rs2_addr`=0; `shft_amnt`=0.
- **OP-IMM shifts:**
  - funct3 001 with instr[31:25]=0000000 → sll.
  - funct3 101 with instr[31:25]=0000000 → srl; with 0100000 → sra.
  - `shft_amnt` = `imm_val` = {27'b0, instr[24:20]}; `use_imm`=1.
  - Any other instr[31:25] → illegal.
- **Fields:** `rs1_addr`=instr[19:15], `rd_addr`=instr[11:7]. For OP, `rs2_addr`=instr[24:20].
- **Illegal bundle:**
  - `illegal`=1, `alu_control`=0, `use_imm`=0, `imm_val`=0, `shft_amnt`=0, all addresses 0.
  - Delivered downstream like any other bundle so the trap logic sees it in order.
- **Buffering:**
  - Output register plus one skid register.
  - `in_ready` = !skid_valid, driven from a register, never combinationally from `out_ready`.
  - An accept while the output is held (`out_valid`=1, `out_ready`=0) loads the skid register.
  - When the output drains, the skid entry moves to the output first; order is strictly FIFO.
- **Flush:**
  - `flush`=1 clears `out_valid` and skid_valid at the next edge.
  - `in_ready` is forced 0 during the flush cycle; no input is accepted in that cycle.
  - Flush has priority over every other event.

## Timing
- **Reset (asynchronous):**
  - `out_valid`=0, `illegal`=0, `use_imm`=0.
  - `alu_control`, `imm_val`, `shft_amnt` and all addresses = 0.
  - skid_valid=0, so `in_ready`=1 after reset deassertion.
  - No accept occurs while `rst_n`=0.
- **Latency:** accept on edge N → `out_valid`=1 with decoded fields after edge N. One-cycle latency.
- **Throughput:** 1 instruction/cycle while `out_ready`=1.
- **Output handshake:** fields are stable while `out_valid`=1 and `out_ready`=0.
- **Simultaneous accept and drain:**
  - Output full, `out_ready`=1, skid empty: new bundle goes directly to the output.
  - Skid full: the skid entry goes to the output and a new accept is impossible (`in_ready`=0).
- **Buffer full:** both registers hold data; `in_ready`=0 until `out_ready`=1. `in_ready` then returns to 1 one cycle after the drain.
- **Reset mid-stream:** buffered instructions are discarded with no partial output.

## Test plan
- **ADD:** 0x002081B3 → `alu_control`=000000, rs1=1, rs2=2, rd=3, `use_imm`=0, `illegal`=0, one cycle after accept.
- **SUB and ADDI:**
  - 0x402081B3 → 001000.
  - 0xFFF00293 → 000000, `imm_val`=0xFFFFFFFF, `use_imm`=1, rd=5, rs2=0.
- **SRAI:** 0x40715093 → 001001, `shft_amnt`=7, `imm_val`=7, rs1=2, rd=1. Changing instr[31:25] to 0100001 → `illegal`=1, `alu_control`=0.
- **Back-pressure:** stream 0x002081B3, 0x402081B3, 0xFFF00293 with `out_ready`=0 for 3 cycles.
  - `in_ready` falls after the second accept.
  - Releasing `out_ready` delivers all three in order with no loss and no duplication.
- **Illegal opcode:** 0x0000007F → bundle delivered with `illegal`=1 and all other outputs 0.
- **Flush and reset:**
  - With 2 bundles buffered, `flush` for 1 cycle → `out_valid`=0 next cycle and `in_ready`=1 the cycle after; no stale bundle appears.
  - Repeat using `rst_n` pulsed low mid-cycle → outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/alu_op_decoder.sv
// Decode stage for RV32I OP / OP-IMM: turns an instruction word into the ALU
// control bundle, with a registered output plus one skid entry (FIFO order).
module alu_op_decoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  alu_control,
   output logic [31:0] imm_val,
   output logic [31:0] shft_amnt,
   output logic        use_imm,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [4:0]  rd_addr,
   output logic        illegal
);

   typedef enum logic [5:0] {
      ALU_ADD  = 6'd0,
      ALU_SLT  = 6'd1,
      ALU_SLTU = 6'd2,
      ALU_AND  = 6'd3,
      ALU_OR   = 6'd4,
      ALU_XOR  = 6'd5,
      ALU_SLL  = 6'd6,
      ALU_SRL  = 6'd7,
      ALU_SUB  = 6'd8,
      ALU_SRA  = 6'd9
   } alu_op_e;

   typedef struct packed {
      logic        illegal;
      logic [5:0]  alu_control;
      logic        use_imm;
      logic [31:0] imm_val;
      logic [31:0] shft_amnt;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
   } bundle_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       legal;
   alu_op_e    op;
   bundle_t    dec;
   bundle_t    out_q;
   bundle_t    skid_q;
   logic       skid_valid;
   logic       accept;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      legal = 1'b0;
      op    = ALU_ADD;
      dec   = '0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               case (funct3)
                  3'b000:  op = ALU_ADD;
                  3'b001:  op = ALU_SLL;
                  3'b010:  op = ALU_SLT;
                  3'b011:  op = ALU_SLTU;
                  3'b100:  op = ALU_XOR;
                  3'b101:  op = ALU_SRL;
                  3'b110:  op = ALU_OR;
                  default: op = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000) begin
                  legal = 1'b1;
                  op    = ALU_SUB;
               end else if (funct3 == 3'b101) begin
                  legal = 1'b1;
                  op    = ALU_SRA;
               end
            end
         end
         OPC_OP_IMM: begin
            case (funct3)
               3'b001: begin
                  legal = (funct7 == F7_BASE);
                  op    = ALU_SLL;
               end
               3'b101: begin
                  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                  op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               end
               3'b000:  begin legal = 1'b1; op = ALU_ADD;  end
               3'b010:  begin legal = 1'b1; op = ALU_SLT;  end
               3'b011:  begin legal = 1'b1; op = ALU_SLTU; end
               3'b100:  begin legal = 1'b1; op = ALU_XOR;  end
               3'b110:  begin legal = 1'b1; op = ALU_OR;   end
               default: begin legal = 1'b1; op = ALU_AND;  end
            endcase
         end
         default: ;
      endcase

      // Illegal bundles carry only the flag so trap logic sees clean zeros.
      if (legal) begin
         dec.alu_control = op;
         dec.rs1_addr    = in_instr[19:15];
         dec.rd_addr     = in_instr[11:7];
         if (opcode == OPC_OP) begin
            dec.rs2_addr = in_instr[24:20];
         end else begin
            dec.use_imm = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.imm_val   = {27'b0, in_instr[24:20]};
               dec.shft_amnt = {27'b0, in_instr[24:20]};
            end else begin
               dec.imm_val = {{20{in_instr[31]}}, in_instr[31:20]};
            end
         end
      end else begin
         dec.illegal = 1'b1;
      end
   end

   assign in_ready = !skid_valid && !flush;
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_q      <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         // Output is necessarily full here; the skid entry drains first.
         if (out_ready) begin
            out_q      <= skid_q;
            skid_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid || out_ready) begin
            out_q     <= dec;
            out_valid <= 1'b1;
         end else begin
            skid_valid <= 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // NOTE: the skid payload is qualified by skid_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept && out_valid && !out_ready) skid_q <= dec;
   end

   assign alu_control = out_q.alu_control;
   assign imm_val     = out_q.imm_val;
   assign shft_amnt   = out_q.shft_amnt;
   assign use_imm     = out_q.use_imm;
   assign rs1_addr    = out_q.rs1_addr;
   assign rs2_addr    = out_q.rs2_addr;
   assign rd_addr     = out_q.rd_addr;
   assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: scoreboard of decoded bundles plus
// directed checks for latency, back-pressure, flush and asynchronous reset.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready;
   logic        out_valid;
   logic [5:0]  alu_control;
   logic [31:0] imm_val;
   logic [31:0] shft_amnt;
   logic        use_imm;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        illegal;

   alu_op_decoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_control (alu_control),
      .imm_val     (imm_val),
      .shft_amnt   (shft_amnt),
      .use_imm     (use_imm),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rd_addr     (rd_addr),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        illegal;
      logic [5:0]  alu;
      logic        use_imm;
      logic [31:0] imm;
      logic [31:0] sh;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } exp_t;

   exp_t got;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   assign got = {illegal, alu_control, use_imm, imm_val, shft_amnt, rs1_addr, rs2_addr, rd_addr};

   task automatic check(input string tag, input logic [95:0] actual, input logic [95:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, actual, expected);
   endtask

   // Reference decoder, table-driven by funct3 and the funct7/funct3 key.
   function automatic exp_t model(input logic [31:0] i);
      exp_t e;
      int   code;
      int   op_map[8];
      logic [9:0] key;
      op_map = '{0, 6, 1, 2, 5, 7, 4, 3};
      e      = '0;
      code   = -1;
      key    = {i[31:25], i[14:12]};
      if (i[6:0] == 7'h33) begin
         if (i[31:25] == 7'h00) code = op_map[i[14:12]];
         else if (key == {7'h20, 3'd0}) code = 8;
         else if (key == {7'h20, 3'd5}) code = 9;
      end else if (i[6:0] == 7'h13) begin
         case (i[14:12])
            3'd1: if (i[31:25] == 7'h00) code = 6;
            3'd5: begin
               if (i[31:25] == 7'h00) code = 7;
               else if (i[31:25] == 7'h20) code = 9;
            end
            default: code = op_map[i[14:12]];
         endcase
      end
      if (code < 0) begin
         e.illegal = 1'b1;
      end else begin
         e.alu = 6'(code);
         e.rs1 = i[19:15];
         e.rd  = i[11:7];
         if (i[6:0] == 7'h33) begin
            e.rs2 = i[24:20];
         end else begin
            e.use_imm = 1'b1;
            if (i[13:12] == 2'b01) begin
               e.imm = 32'(i[24:20]);
               e.sh  = e.imm;
            end else begin
               e.imm = 32'($signed(i[31:20]));
            end
         end
      end
      return e;
   endfunction

   // Handshakes are observed mid-cycle, ahead of the edge that completes them.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 96'(got), 96'(0));
            end else begin
               e = sb.pop_front();
               check("bundle", 96'(got), 96'(e));
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(model(in_instr));
      end
   end

   task automatic send(input logic [31:0] instr);
      int t = 0;
      in_valid = 1'b1;
      in_instr = instr;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("send_timeout", 96'(t < 50), 96'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      step(1);
      check("rst_bundle", 96'(got), 96'(0));
      check("rst_valid_ready", 96'({out_valid, in_ready}), 96'(2'b01));
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      check("post_rst_ready", 96'(in_ready), 96'(1));

      // Single-op decode, one-cycle latency, back-to-back throughput
      out_ready = 1'b1;
      send(32'h002081B3);
      check("add_fields", 96'({out_valid, alu_control, rs1_addr, rs2_addr, rd_addr, use_imm, illegal}),
            96'({1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0}));
      send(32'h402081B3);
      check("sub_alu", 96'(alu_control), 96'(6'b001000));
      send(32'hFFF00293);
      check("addi_fields", 96'({alu_control, imm_val, use_imm, rd_addr, rs2_addr}),
            96'({6'd0, 32'hFFFFFFFF, 1'b1, 5'd5, 5'd0}));
      send(32'h40715093);
      check("srai_fields", 96'({alu_control, shft_amnt, imm_val, rs1_addr, rd_addr}),
            96'({6'b001001, 32'd7, 32'd7, 5'd2, 5'd1}));
      send(32'h42715093);
      check("srai_bad_f7", 96'({illegal, alu_control}), 96'({1'b1, 6'd0}));
      send(32'h0000007F);
      check("illegal_opcode", 96'({out_valid, got}), 96'({1'b1, 1'b1, 86'd0}));
      for (int k = 0; k < 8; k++) send({7'h00, 5'(k + 3), 5'(k), 3'(k), 5'(k + 1), 7'h13});
      step(2);
      check("idle_drained", 96'(out_valid), 96'(0));

      // Back-pressure: two accepts fill the buffer, third waits
      out_ready = 1'b0;
      send(32'h002081B3);
      send(32'h402081B3);
      check("bp_ready_low", 96'(in_ready), 96'(0));
      in_valid = 1'b1;
      in_instr = 32'hFFF00293;
      step(2);
      check("bp_held", 96'({in_ready, out_valid, alu_control}), 96'({1'b0, 1'b1, 6'd0}));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(1);
      check("bp_ready_back", 96'({in_ready, alu_control}), 96'({1'b1, 6'b001000}));
      send(32'hFFF00293);
      step(3);
      check("bp_drained", 96'({out_valid, sb.size() == 0}), 96'(2'b01));

      // Flush with two bundles buffered
      out_ready = 1'b0;
      send(32'h002081B3);
      send(32'h40715093);
      flush = 1'b1;
      #1;
      check("flush_ready_low", 96'(in_ready), 96'(0));
      step(1);
      flush = 1'b0;
      #1;
      check("flush_cleared", 96'({out_valid, in_ready}), 96'(2'b01));
      out_ready = 1'b1;
      step(3);
      check("flush_no_stale", 96'(out_valid), 96'(0));

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'h402081B3);
      send(32'hFFF00293);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 96'({out_valid, in_ready, got}), 96'({1'b0, 1'b1, 87'd0}));
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step(2);
      check("rst_no_stale", 96'(out_valid), 96'(0));
      send(32'h0020E1B3);
      step(3);
      check("sb_empty", 96'(sb.size()), 96'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
